mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  EX->MEM pipeline register plus load/store unit. Consumes the execute-stage ALU result
//  (address or data) and the store data, runs sb/sh/sw and lb/lh/lw/lbu/lhu on a req/ack data-memory bus,
//  and hands the write-back value to the WB stage. Holds the pipeline via stall_out during memory access.
// PARAMETERS
//  TIMEOUT_CYCLES  default 16  max ACCESS cycles without dmem_ack before the bus error is raised (>=2)
//  CNT_W           default 5   width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk            in   1   rising-edge clock; sole clock of the block
//  rst            in   1   synchronous, active-high reset
//  ex_valid       in   1   execute-stage outputs valid this cycle
//  ex_type        in   3   instruction class: R=011 I_logic=001 I_load=000 S=010 U=101; others no-op
//  ex_func        in   3   funct3: load 000 lb,001 lh,010 lw,100 lbu,101 lhu; store 000 sb,001 sh,010 sw
//  ex_aluout      in   32  ALU result; effective address for I_load/S
//  ex_store_data  in   32  store data (rs2); ignored unless S
//  ex_rd          in   5   destination register
//  stall_out      out  1   upstream must hold ex_* stable while high
//  dmem_req       out  1   memory request; held until ack
//  dmem_we        out  1   1=write
//  dmem_addr      out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables
//  dmem_rdata     in   32  read data, valid with dmem_ack
//  dmem_ack       in   1   completion; one-cycle pulse
//  wb_valid       out  1   one-cycle pulse: result/exception for WB
//  wb_data        out  32  write-back value
//  wb_rd          out  5   destination register
//  wb_regwrite    out  1   register-file write enable (qualified by wb_valid)
//  misalign_err   out  1   with wb_valid: misaligned access, no memory op issued
//  bus_err        out  1   with wb_valid: ack timeout, access abandoned
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, including every dmem_* and wb_* output, are 0; timeout counter is 0.
//  FSM: IDLE, ACCESS. stall_out = (state==ACCESS), combinational.
//  IDLE accepts when ex_valid=1:
//   - R/I_logic/U: next cycle wb_valid=1, wb_data=ex_aluout, wb_regwrite=(ex_rd!=0). Latency 1.
//   - I_load/S, aligned: register address/data/be, drive dmem_req=1 next cycle, go ACCESS.
//   - Misaligned (h: addr[0]; w: addr[1:0]!=0; b never): no request; next cycle wb_valid=1,
//     misalign_err=1, wb_regwrite=0.
//   - Undefined func for load/store: treated as misaligned.
//   - Other ex_type: no-op; wb_valid stays 0.
//  ACCESS: dmem_req and all dmem_* outputs stay stable until dmem_ack; ack is legal in the first ACCESS cycle.
//   - On ack: dmem_req=0 next cycle, state->IDLE, wb_valid=1 same next cycle.
//     Load: wb_data = lane selected by addr[1:0], sign- or zero-extended; wb_regwrite=(rd!=0).
//     Store: wb_regwrite=0.
//   - Counter increments each ACCESS cycle without ack. At TIMEOUT_CYCLES: dmem_req=0, bus_err=1,
//     wb_valid=1, wb_regwrite=0, state->IDLE. An ack arriving in the timeout cycle wins.
//  Store lanes: sb be=0001<<a[1:0], wdata={4{b}}; sh be=0011<<a[1:0] (a[1] only), wdata={2{h}};
//   sw be=1111.
//  Load: be=1111, dmem_we=0.
//  dmem_ack in IDLE (late/spurious): ignored, no output change.
//  Back-to-back: a new instruction is accepted in the IDLE cycle immediately following ack or timeout.
//  Reset mid-ACCESS: dmem_req drops at that edge; the pending op is discarded without write-back.
//  wb_valid, misalign_err and bus_err are single-cycle pulses; wb_data/wb_rd hold until the next wb_valid.
// STRUCTURE
//  Shared package (rv_pkg): ex_type codes (R/S/B/J/U/I_jump/I_logic/I_load), load/store funct3 codes,
//   FSM state encoding.
//  One sub-module, load_extend: combinational lane select plus sign/zero extension from rdata, a[1:0]
//   and func. Byte-enable and wdata generation stay inline.
// TESTING
//  1. R op, ex_aluout=0x0000_0005, rd=3 -> next cycle wb_valid=1, wb_data=5, wb_regwrite=1;
//     stall_out never asserts.
//  2. sb addr=0x103, data=0xAB, ack after 3 cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB;
//     stall_out high for 3 cycles; wb_regwrite=0.
//  3. lb addr=0x102, rdata=0x0080_0000 -> wb_data=0xFFFF_FF80.
//     lbu with the same address and rdata -> 0x0000_0080.
//     lhu addr=0x102, rdata=0x8001_0000 -> 0x0000_8001.
//  4. lw addr=0x106 -> no dmem_req; wb_valid=1, misalign_err=1, wb_regwrite=0 the next cycle.
//  5. lw with no ack -> dmem_req high for 16 cycles, then bus_err=1 pulse and return to IDLE.
//     A late ack afterwards is ignored.
//  6. rst during ACCESS -> dmem_req=0 and all wb_* outputs 0 next cycle.
//     lw rd=0 with ack -> wb_regwrite=0.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared instruction-class, funct3 and FSM encodings for the
//             memory-access stage.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam logic [2:0] c_type_i_load  = 3'b000;
  localparam logic [2:0] c_type_i_logic = 3'b001;
  localparam logic [2:0] c_type_s       = 3'b010;
  localparam logic [2:0] c_type_r       = 3'b011;
  localparam logic [2:0] c_type_b       = 3'b100;
  localparam logic [2:0] c_type_u       = 3'b101;
  localparam logic [2:0] c_type_i_jump  = 3'b110;
  localparam logic [2:0] c_type_j       = 3'b111;

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Undefined funct3 codes are folded into the misaligned case.
  function automatic logic access_misaligned(input logic       is_store,
                                             input logic [2:0] func,
                                             input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (func)
      c_f3_lb:  bad = 1'b0;
      c_f3_lh:  bad = lo[0];
      c_f3_lw:  bad = (lo != 2'b00);
      c_f3_lbu: bad = is_store;
      c_f3_lhu: bad = is_store | lo[0];
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage_if
//  Purpose  : Data-memory req/ack bus between the stage (master) and memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Selects the addressed byte/half lane of read data and applies
//             sign or zero extension.
//  Revision : 1.0 - initial release
// ============================================================================
module load_extend
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  func,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (lane)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = lane[1] ? rdata[31:16] : rdata[15:0];

    case (func)
      c_f3_lb:  data = {{24{w_byte[7]}}, w_byte};
      c_f3_lbu: data = {24'd0, w_byte};
      c_f3_lh:  data = {{16{w_half[15]}}, w_half};
      c_f3_lhu: data = {16'd0, w_half};
      default:  data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : EX->MEM pipeline register and load/store unit driving a req/ack
//             data-memory bus, with misalignment and ack-timeout reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [2:0]          ex_type,
  input  logic [2:0]          ex_func,
  input  logic [31:0]         ex_aluout,
  input  logic [31:0]         ex_store_data,
  input  logic [4:0]          ex_rd,
  output logic                stall_out,
  mem_access_stage_if.master  dmem,
  output logic                wb_valid,
  output logic [31:0]         wb_data,
  output logic [4:0]          wb_rd,
  output logic                wb_regwrite,
  output logic                misalign_err,
  output logic                bus_err
);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_lane;
  logic [2:0]  r_func;
  logic [4:0]  r_rd;
  logic        r_is_load;
  logic [CNT_W-1:0] r_cnt;

  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_regwrite;
  logic        r_misalign;
  logic        r_bus_err;

  logic        w_is_alu;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_accept;
  logic        w_done_ack;
  logic        w_done_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_is_alu   = (ex_type == c_type_r) || (ex_type == c_type_i_logic) ||
                      (ex_type == c_type_u);
  assign w_is_load  = (ex_type == c_type_i_load);
  assign w_is_store = (ex_type == c_type_s);
  assign w_misalign = access_misaligned(w_is_store, ex_func, ex_aluout[1:0]);
  assign w_accept   = (r_state == ST_IDLE) && ex_valid &&
                      (w_is_alu || w_is_load || w_is_store);

  // An ack in the final counted cycle takes priority over the timeout.
  assign w_done_ack     = (r_state == ST_ACCESS) && dmem.dmem_ack;
  assign w_done_timeout = (r_state == ST_ACCESS) && !dmem.dmem_ack &&
                          (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_store_data;
    if (w_is_store) begin
      case (ex_func)
        c_f3_sb: begin
          w_be    = 4'b0001 << ex_aluout[1:0];
          w_wdata = {4{ex_store_data[7:0]}};
        end
        c_f3_sh: begin
          w_be    = ex_aluout[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{ex_store_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_store_data;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata (dmem.dmem_rdata),
    .lane  (r_lane),
    .func  (r_func),
    .data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    stall_out    = (r_state == ST_ACCESS);
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_is_alu && !w_misalign) w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_done_ack || w_done_timeout) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_lane        <= '0;
      r_func        <= '0;
      r_rd          <= '0;
      r_is_load     <= 1'b0;
      r_cnt         <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_misalign    <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      if (w_accept) begin
        if (w_is_alu) begin
          r_wb_valid    <= 1'b1;
          r_wb_data     <= ex_aluout;
          r_wb_rd       <= ex_rd;
          r_wb_regwrite <= (ex_rd != 5'd0);
        end else if (w_misalign) begin
          r_wb_valid    <= 1'b1;
          r_misalign    <= 1'b1;
          r_wb_data     <= ex_aluout;
          r_wb_rd       <= ex_rd;
          r_wb_regwrite <= 1'b0;
        end else begin
          r_req     <= 1'b1;
          r_we      <= w_is_store;
          r_addr    <= {ex_aluout[31:2], 2'b00};
          r_wdata   <= w_is_store ? w_wdata : 32'd0;
          r_be      <= w_be;
          r_lane    <= ex_aluout[1:0];
          r_func    <= ex_func;
          r_rd      <= ex_rd;
          r_is_load <= w_is_load;
          r_cnt     <= '0;
        end
      end else if (w_done_ack) begin
        r_req      <= 1'b0;
        r_cnt      <= '0;
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        if (r_is_load) begin
          r_wb_data     <= w_load_data;
          r_wb_regwrite <= (r_rd != 5'd0);
        end else begin
          r_wb_regwrite <= 1'b0;
        end
      end else if (w_done_timeout) begin
        r_req         <= 1'b0;
        r_cnt         <= '0;
        r_bus_err     <= 1'b1;
        r_wb_valid    <= 1'b1;
        r_wb_rd       <= r_rd;
        r_wb_regwrite <= 1'b0;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_be    = r_be;

  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign wb_regwrite  = r_wb_regwrite;
  assign misalign_err = r_misalign;
  assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench: directed cases plus randomized operations
//             compared against a behavioural load/store reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_type;
  logic [2:0]  ex_func;
  logic [31:0] ex_aluout;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall_out;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        misalign_err;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  // Last architecturally defined write-back value, for the hold check.
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  bit          m_known;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_type       (ex_type),
    .ex_func       (ex_func),
    .ex_aluout     (ex_aluout),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .stall_out     (stall_out),
    .dmem          (dmem_bus),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_regwrite   (wb_regwrite),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"},      32'(dmem_bus.dmem_req),   0);
    chk({tag, "_we"},       32'(dmem_bus.dmem_we),    0);
    chk({tag, "_addr"},     dmem_bus.dmem_addr,       0);
    chk({tag, "_wdata"},    dmem_bus.dmem_wdata,      0);
    chk({tag, "_be"},       32'(dmem_bus.dmem_be),    0);
    chk({tag, "_wbvalid"},  32'(wb_valid),            0);
    chk({tag, "_wbdata"},   wb_data,                  0);
    chk({tag, "_wbrd"},     32'(wb_rd),               0);
    chk({tag, "_regwrite"}, 32'(wb_regwrite),         0);
    chk({tag, "_misalign"}, 32'(misalign_err),        0);
    chk({tag, "_buserr"},   32'(bus_err),             0);
    chk({tag, "_stall"},    32'(stall_out),           0);
  endtask

  // Called at posedge+1; issues one instruction and checks its whole lifetime.
  task automatic run_op(input logic [2:0] typ, input logic [2:0] func,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input int ack_dly,
                        input logic [31:0] rdat);
    bit is_alu, is_ld, is_st, legal, sgn, mis, done;
    int size, off, cyc, want_cyc;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld, e_addr;
    longint      v;

    is_alu = (typ == 3'b011) || (typ == 3'b001) || (typ == 3'b101);
    is_ld  = (typ == 3'b000);
    is_st  = (typ == 3'b010);
    legal  = 1'b1;
    sgn    = 1'b0;
    size   = 1;
    if (is_ld) begin
      case (func)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: legal = 1'b0;
      endcase
    end else if (is_st) begin
      case (func)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: legal = 1'b0;
      endcase
    end
    off    = int'(a % 32'd4);
    mis    = (is_ld || is_st) && (!legal || (off % size) != 0);
    e_addr = a - 32'(off);
    e_be   = is_st ? 4'(((1 << size) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = 8'((sd >> (8 * (i % size))) & 32'hFF);
    v = longint'(rdat >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (sgn && v[8*size-1]) v = v - (longint'(1) << (8 * size));
    e_ld = v[31:0];

    @(negedge clk);
    ex_valid = 1'b1; ex_type = typ; ex_func = func;
    ex_aluout = a; ex_store_data = sd; ex_rd = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0;

    if (is_alu) begin
      chk("alu_wbvalid",  32'(wb_valid), 1);
      chk("alu_wbdata",   wb_data, a);
      chk("alu_wbrd",     32'(wb_rd), 32'(rd));
      chk("alu_regwrite", 32'(wb_regwrite), 32'(rd != 0));
      chk("alu_misalign", 32'(misalign_err), 0);
      chk("alu_stall",    32'(stall_out), 0);
      chk("alu_req",      32'(dmem_bus.dmem_req), 0);
      m_known = 1'b1; m_data = a; m_rd = rd;
    end else if (!(is_ld || is_st)) begin
      chk("nop_wbvalid", 32'(wb_valid), 0);
      chk("nop_req",     32'(dmem_bus.dmem_req), 0);
      chk("nop_stall",   32'(stall_out), 0);
    end else if (mis) begin
      chk("mis_wbvalid",  32'(wb_valid), 1);
      chk("mis_flag",     32'(misalign_err), 1);
      chk("mis_regwrite", 32'(wb_regwrite), 0);
      chk("mis_buserr",   32'(bus_err), 0);
      chk("mis_req",      32'(dmem_bus.dmem_req), 0);
      chk("mis_stall",    32'(stall_out), 0);
      m_known = 1'b0;
    end else begin
      cyc      = 0;
      done     = 1'b0;
      want_cyc = (ack_dly >= 0) ? ack_dly + 1 : TO;
      while (!done) begin
        cyc++;
        chk("acc_req",     32'(dmem_bus.dmem_req), 1);
        chk("acc_stall",   32'(stall_out), 1);
        chk("acc_we",      32'(dmem_bus.dmem_we), 32'(is_st));
        chk("acc_addr",    dmem_bus.dmem_addr, e_addr);
        chk("acc_be",      32'(dmem_bus.dmem_be), 32'(e_be));
        chk("acc_wbvalid", 32'(wb_valid), 0);
        if (is_st) chk("acc_wdata", dmem_bus.dmem_wdata, e_wd);
        if (ack_dly >= 0 && cyc == want_cyc) begin
          dmem_bus.dmem_ack   = 1'b1;
          dmem_bus.dmem_rdata = rdat;
        end else begin
          dmem_bus.dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        dmem_bus.dmem_ack = 1'b0;
        if (cyc >= want_cyc) done = 1'b1;
      end
      chk("end_wbvalid",  32'(wb_valid), 1);
      chk("end_req",      32'(dmem_bus.dmem_req), 0);
      chk("end_stall",    32'(stall_out), 0);
      chk("end_misalign", 32'(misalign_err), 0);
      if (ack_dly >= 0) begin
        chk("end_buserr", 32'(bus_err), 0);
        if (is_ld) begin
          chk("ld_data",     wb_data, e_ld);
          chk("ld_rd",       32'(wb_rd), 32'(rd));
          chk("ld_regwrite", 32'(wb_regwrite), 32'(rd != 0));
          m_known = 1'b1; m_data = e_ld; m_rd = rd;
        end else begin
          chk("st_regwrite", 32'(wb_regwrite), 0);
          m_known = 1'b0;
        end
      end else begin
        chk("to_buserr",   32'(bus_err), 1);
        chk("to_regwrite", 32'(wb_regwrite), 0);
        m_known = 1'b0;
      end
    end
  endtask

  // One cycle with nothing issued, optionally with a stray ack on the bus.
  task automatic idle_cycle(input bit spurious);
    dmem_bus.dmem_ack   = spurious;
    dmem_bus.dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
    chk("idle_wbvalid",  32'(wb_valid), 0);
    chk("idle_misalign", 32'(misalign_err), 0);
    chk("idle_buserr",   32'(bus_err), 0);
    chk("idle_req",      32'(dmem_bus.dmem_req), 0);
    chk("idle_stall",    32'(stall_out), 0);
    if (m_known) begin
      chk("hold_wbdata", wb_data, m_data);
      chk("hold_wbrd",   32'(wb_rd), 32'(m_rd));
    end
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    ex_valid = 1'b1; ex_type = 3'b000; ex_func = 3'd2;
    ex_aluout = 32'h200; ex_store_data = 32'h0; ex_rd = 5'd9;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rstmid_req_before", 32'(dmem_bus.dmem_req), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("rstmid");
    m_known = 1'b1; m_data = 32'd0; m_rd = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, dly;
    logic [2:0] t, f;

    rst = 1'b1;
    ex_valid = 1'b0; ex_type = 3'd0; ex_func = 3'd0;
    ex_aluout = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    m_known = 1'b1; m_data = 32'd0; m_rd = 5'd0;

    run_op(3'b011, 3'd0, 32'h0000_0005, 32'h0, 5'd3, 0, 32'h0);
    idle_cycle(1'b0);
    run_op(3'b010, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd7, 2, 32'h0);
    run_op(3'b000, 3'd0, 32'h0000_0102, 32'h0, 5'd5, 1, 32'h0080_0000);
    run_op(3'b000, 3'd4, 32'h0000_0102, 32'h0, 5'd6, 0, 32'h0080_0000);
    run_op(3'b000, 3'd5, 32'h0000_0102, 32'h0, 5'd8, 3, 32'h8001_0000);
    run_op(3'b000, 3'd2, 32'h0000_0106, 32'h0, 5'd4, 0, 32'h0);
    idle_cycle(1'b0);
    run_op(3'b000, 3'd2, 32'h0000_0200, 32'h0, 5'd4, -1, 32'h0);
    idle_cycle(1'b1);
    reset_mid_access();
    idle_cycle(1'b1);
    run_op(3'b000, 3'd2, 32'h0000_0204, 32'h0, 5'd0, 0, 32'hDEAD_BEEF);
    run_op(3'b000, 3'd1, 32'h0000_0302, 32'h0, 5'd2, TO - 1, 32'h9234_5678);
    run_op(3'b010, 3'd1, 32'h0000_0302, 32'h1234_CAFE, 5'd1, 1, 32'h0);
    run_op(3'b010, 3'd3, 32'h0000_0300, 32'h0, 5'd1, 0, 32'h0);
    run_op(3'b100, 3'd0, 32'h0000_0300, 32'h0, 5'd1, 0, 32'h0);
    idle_cycle(1'b0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       t = 3'b000;
      else if (r < 7)  t = 3'b010;
      else if (r == 7) begin
        case ($urandom_range(0, 2))
          0:       t = 3'b011;
          1:       t = 3'b001;
          default: t = 3'b101;
        endcase
      end else t = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) begin
        if (t == 3'b000) begin
          f = 3'($urandom_range(0, 4));
          if (f == 3'd3) f = 3'd5;
        end else f = 3'($urandom_range(0, 2));
      end else f = 3'($urandom_range(0, 7));
      dly = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 4));
      run_op(t, f, 32'h1000 + 32'($urandom_range(0, 255)), $urandom,
             5'($urandom_range(0, 31)), dly, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
